regfile_write_scheduler: RTL
============================

Name: regfile_write_scheduler

Overview:
- Schedules the single register-file write port between two producers:
  - the in-order pipeline writeback (WB), and
  - a multi-cycle execution unit (MC), e.g. a mult/div unit, that returns results late.
- Keeps a per-register pending scoreboard and raises a decode-stage stall for RAW/WAW hazards against outstanding MC results.
- Sits between the writeback/MC producers and the register file write port (RegWrite, WriteRegister, WriteData), beside the decode stage.

Parameters:
- NBits, 32, data width of a register.
- DEPTH, 2, number of MC result buffer entries (1..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_reg  in  5  WB destination register.
- wb_data  in  NBits  WB data.
- mc_issue  in  1  MC operation issued from decode this cycle.
- mc_issue_reg  in  5  destination register of the issued MC op.
- mc_valid  in  1  MC result offered.
- mc_reg  in  5  MC result destination.
- mc_data  in  NBits  MC result data.
- mc_ready  out  1  scheduler accepts the MC result this cycle.
- rs_addr  in  5  decode source register 1.
- rt_addr  in  5  decode source register 2.
- rs_used  in  1  rs_addr is a real operand.
- rt_used  in  1  rt_addr is a real operand.
- RegWrite  out  1  register file write enable (registered).
- WriteRegister  out  5  register file write address (registered).
- WriteData  out  NBits  register file write data (registered).
- hazard_stall  out  1  decode must hold; combinational.
- buf_count  out  3  occupied MC buffer entries.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - Buffer empty, buf_count=0, scoreboard busy[31:0]=0, proto_err=0.
  - mc_ready=1 once reset is released.
  - A reset asserted mid-operation discards all buffered results and pending bits.
- mc_ready = (buf_count < DEPTH). The MC handshake completes on an edge where mc_valid && mc_ready.
- Accepted MC results enter a FIFO (circular pointers, wrap at DEPTH).
- Per-cycle write-port selection, registered to the outputs at the next edge (latency 1):
  1. wb_valid && wb_reg!=0: drive WB, RegWrite=1. WB is never stalled or buffered.
  2. Otherwise, FIFO non-empty: pop the head and drive it.
  3. Otherwise, FIFO empty and an MC result is accepted this cycle: bypass it straight to the port, with no buffer entry.
  4. Otherwise: RegWrite=0, WriteRegister/WriteData hold their previous values.
- Simultaneous cases:
  - Pop plus push in the same cycle: buf_count is unchanged.
  - MC accepted while WB wins the port: the result is pushed to the FIFO.
- Register 0:
  - WB or MC writes to register 0 are dropped: never driven, never buffered.
  - An MC result for register 0 is still accepted (handshake completes).
- Scoreboard:
  - mc_issue && mc_issue_reg!=0 sets busy[mc_issue_reg] at the edge.
  - busy[r] clears at the edge where RegWrite=1 && WriteRegister==r is driven from an MC source.
  - Same-edge set and clear of the same register: set wins.
- hazard_stall = (rs_used && busy[rs_addr]) || (rt_used && busy[rt_addr]) || (mc_issue && busy[mc_issue_reg]).
  - Stall drops the cycle after the MC write is driven on the port.
- proto_err is set, and held until reset, on any of:
  - wb_valid to a busy register;
  - an accepted MC result whose mc_reg is not busy (and !=0);
  - mc_issue to an already busy register.
  - The offending write is still performed.

Test Plan:
- Reset released, no traffic -> RegWrite=0, mc_ready=1, buf_count=0, hazard_stall=0, proto_err=0.
- WB-only write: wb_valid=1, wb_reg=5, wb_data=0xAAAA5555 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xAAAA5555; the following cycle RegWrite=0.
- MC path:
  - mc_issue reg 8 -> busy[8]=1.
  - Decode with rs_addr=8, rs_used=1 -> hazard_stall=1.
  - MC result (8, 0x12) with no WB -> bypass; port shows reg 8 / 0x12 next cycle.
  - hazard_stall=0 one cycle later.
- Contention:
  - Issue regs 9 and 10.
  - WB valid on 3 consecutive cycles while MC offers results 9 and 10 -> both buffered; buf_count=2; mc_ready=0.
  - MC results then drain in order 9, 10 once WB idles.
- Zero register: WB to reg 0 and MC result to reg 0 -> RegWrite stays 0; the MC handshake still completes.
- Errors and reset:
  - mc_issue to reg 8 while busy[8]=1 -> hazard_stall=1, proto_err=1.
  - Assert reset with 2 buffered entries -> buf_count=0, busy all 0, proto_err=0 immediately.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between pipeline writeback and a
// multi-cycle unit, tracking outstanding MC destinations for decode hazards.
module regfile_write_scheduler #(
  parameter int NBits = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic [NBits-1:0] wb_data,
  input  logic             mc_issue,
  input  logic [4:0]       mc_issue_reg,
  input  logic             mc_valid,
  input  logic [4:0]       mc_reg,
  input  logic [NBits-1:0] mc_data,
  output logic             mc_ready,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             RegWrite,
  output logic [4:0]       WriteRegister,
  output logic [NBits-1:0] WriteData,
  output logic             hazard_stall,
  output logic [2:0]       buf_count,
  output logic             proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [2:0]    DEPTH_C  = 3'(DEPTH);

  logic [4:0]       r_fifo_reg  [DEPTH];
  logic [NBits-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [2:0]       r_count;
  logic [31:0]      r_busy;
  logic             r_regwrite, r_src_mc, r_perr;
  logic [4:0]       r_wreg;
  logic [NBits-1:0] r_wdata;

  logic             w_wb_go, w_accept, w_mc_nz, w_pop, w_push, w_bypass, w_err;
  logic [31:0]      w_busy_set, w_busy_clr;
  logic             w_nxt_we, w_nxt_src;
  logic [4:0]       w_nxt_reg;
  logic [NBits-1:0] w_nxt_data;

  assign mc_ready      = (r_count < DEPTH_C);
  assign buf_count     = r_count;
  assign proto_err     = r_perr;
  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
  assign hazard_stall  = (rs_used && r_busy[rs_addr]) || (rt_used && r_busy[rt_addr]) ||
                         (mc_issue && r_busy[mc_issue_reg]);

  always_comb begin
    w_wb_go  = wb_valid && (wb_reg != '0);
    w_accept = mc_valid && mc_ready;
    w_mc_nz  = (mc_reg != '0);
    w_pop    = !w_wb_go && (r_count != '0);
    w_bypass = !w_wb_go && (r_count == '0) && w_accept && w_mc_nz;
    // Register-0 results complete the handshake but are never stored.
    w_push   = w_accept && w_mc_nz && !w_bypass;

    w_nxt_we   = 1'b0;
    w_nxt_src  = 1'b0;
    w_nxt_reg  = r_wreg;
    w_nxt_data = r_wdata;
    if (w_wb_go) begin
      w_nxt_we   = 1'b1;
      w_nxt_reg  = wb_reg;
      w_nxt_data = wb_data;
    end else if (w_pop) begin
      w_nxt_we   = 1'b1;
      w_nxt_src  = 1'b1;
      w_nxt_reg  = r_fifo_reg[r_rd_ptr];
      w_nxt_data = r_fifo_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_nxt_we   = 1'b1;
      w_nxt_src  = 1'b1;
      w_nxt_reg  = mc_reg;
      w_nxt_data = mc_data;
    end

    // Busy clears once the MC write has actually been presented to the port.
    w_busy_clr = '0;
    if (r_regwrite && r_src_mc) w_busy_clr[r_wreg] = 1'b1;
    w_busy_set = '0;
    if (mc_issue && (mc_issue_reg != '0)) w_busy_set[mc_issue_reg] = 1'b1;

    w_err = (wb_valid && r_busy[wb_reg]) ||
            (w_accept && w_mc_nz && !r_busy[mc_reg]) ||
            (mc_issue && r_busy[mc_issue_reg]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_regwrite <= 1'b0;
      r_src_mc   <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
      r_perr     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_reg[i]  <= '0;
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_regwrite <= w_nxt_we;
      r_src_mc   <= w_nxt_src;
      r_wreg     <= w_nxt_reg;
      r_wdata    <= w_nxt_data;
      r_busy     <= (r_busy & ~w_busy_clr) | w_busy_set;
      r_count    <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      if (w_err) r_perr <= 1'b1;
      if (w_push) begin
        r_fifo_reg[r_wr_ptr]  <= mc_reg;
        r_fifo_data[r_wr_ptr] <= mc_data;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
    end
  end

endmodule
